alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//   ALU reservation station: accepts renamed ALU-class ops from the dispatcher (ALUen/ALUop/ALUoperand*/ALUtag*).
//   Holds them until both source tags resolve by snooping the ALU and LS result buses (CDB).
//   Issues one ready op per cycle, oldest-index-first, to the ALU execute stage.
//   Sits between the dispatcher and the ALU; back-pressures the dispatcher via rsFull.
// PARAMETERS
//   ENTRIES  8    number of RS slots (power of 2)
//   IDX_W    3    log2(ENTRIES)
//   DATA_W   32   operand/result width (`DataBus)
//   TAG_W    4    rename tag width (`TagBus, prefix + root)
//   NAME_W   5    architectural register name width (`NameBus)
//   OP_W     6    internal opcode width (`OpBus)
//   ADDR_W   32   instruction address width (`InstAddrBus)
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous reset, active-high
//   clear       in   1       sync flush (branch mispredict): drop all entries
//   ALUen       in   1       dispatch valid
//   ALUop       in   OP_W    opcode
//   ALUoperandO in   DATA_W  operand 1 data (valid when ALUtagO==TAG_FREE)
//   ALUoperandT in   DATA_W  operand 2 data (valid when ALUtagT==TAG_FREE)
//   ALUtagO     in   TAG_W   operand 1 producer tag
//   ALUtagT     in   TAG_W   operand 2 producer tag
//   ALUtagW     in   TAG_W   destination tag
//   ALUnameW    in   NAME_W  destination register name
//   ALUaddr     in   ADDR_W  instruction address
//   cdbALUen    in   1       ALU result bus valid
//   cdbALUtag   in   TAG_W   ALU result tag
//   cdbALUdata  in   DATA_W  ALU result data
//   cdbLSen     in   1       LS result bus valid
//   cdbLStag    in   TAG_W   LS result tag
//   cdbLSdata   in   DATA_W  LS result data
//   rsFull      out  1       no free slot (combinational from valid vector)
//   exEn        out  1       issue valid to ALU
//   exOp        out  OP_W    issued opcode
//   exA, exB    out  DATA_W  issued operands
//   exTagW      out  TAG_W   issued destination tag
//   exNameW     out  NAME_W  issued destination name
//   exAddr      out  ADDR_W  issued instruction address
// BEHAVIOUR
//   Reset: all valid bits 0; exEn=0, exOp=`NOP, exA/exB/exAddr=0, exTagW=`tagFree, exNameW=`nameFree.
//   Entry = {valid, op, dataO, dataT, tagO, tagT, tagW, nameW, addr}. Ready = valid & tagO==TAG_FREE & tagT==TAG_FREE.
//   Alloc: ALUen & !rsFull -> write lowest-index free slot at the clock edge.
//     ALUen while rsFull is illegal; the op is dropped and a sim assertion fires.
//   rsFull reflects the pre-edge state. A slot freed by issue in cycle N is allocatable in cycle N+1.
//   Wakeup: each cycle, every valid entry with tagX!=TAG_FREE matching an enabled CDB tag captures that data.
//     tagX becomes TAG_FREE at the edge.
//   Dispatch bypass: an incoming ALUtagO/T that matches an enabled CDB tag in the same cycle is written already resolved.
//   Both CDBs matching the same tag cannot occur legally; if it does, the ALU bus wins.
//   Issue: select the lowest-index Ready entry from registered state. At the edge:
//     - load ex* regs, set exEn=1, clear the entry's valid.
//     - No Ready entry -> exEn=0, other ex* hold.
//   Latency: entry written with both operands ready at edge N -> exEn=1 after edge N+1.
//     Woken at edge N -> issues at edge N+1 at earliest. No same-cycle CDB-to-issue bypass.
//   Simultaneous alloc + issue + wakeup in one cycle are independent. The alloc target is always a free slot, never the issuing slot.
//   clear: at the edge all valid bits go to 0 and exEn goes to 0. clear overrides alloc, issue and wakeup that cycle.
//   Async rst mid-operation: immediate return to reset state; no partial entry survives.
// STRUCTURE
//   Shared defines: TAG_FREE (`tagFree), `NOP, `nameFree, `dataFree, bus widths, `Enable/`Disable.
//   Sub-module lowest_one_sel (ENTRIES-bit vector -> IDX_W index + found flag).
//     Instantiated twice: free-slot select on ~valid, issue select on Ready.
//   Entry storage as per-field reg arrays in this module.
// TESTING
//   1. Reset, dispatch ADD opA=5 opB=7 both tags free -> exEn=1 two edges later; exA=5, exB=7, exTagW=dispatched tag.
//   2. Dispatch with tagO=4'h2 pending; cdbALUen tag 4'h2 data 0x10 two cycles later -> issue one cycle after CDB with exA=0x10.
//   3. Dispatch with tagT=4'h9 in the same cycle cdbLS broadcasts 4'h9 data 0xAB -> entry ready; exB=0xAB at next issue.
//   4. Fill 8 unready entries -> rsFull=1; wake slot 3 -> slot 3 issues; rsFull=0 next cycle; new dispatch lands in slot 3.
//   5. Slots 1 and 5 wake on the same CDB cycle -> slot 1 issues first, slot 5 on the following cycle.
//   6. clear asserted with 4 valid entries plus concurrent ALUen -> next cycle rsFull=0, exEn=0, no later issue of any flushed op.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Widths, free/nop encodings, issue bundle and CDB snoop helper.
package alu_rs_pkg;

  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int NAME_W  = 5;
  localparam int OP_W    = 6;
  localparam int ADDR_W  = 32;

  localparam logic              ENABLE    = 1'b1;
  localparam logic              DISABLE   = 1'b0;
  localparam logic [TAG_W-1:0]  TAG_FREE  = '0;
  localparam logic [OP_W-1:0]   NOP       = '0;
  localparam logic [NAME_W-1:0] NAME_FREE = '0;
  localparam logic [DATA_W-1:0] DATA_FREE = '0;
  localparam logic [ADDR_W-1:0] ADDR_FREE = '0;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag_w;
    logic [NAME_W-1:0] name_w;
    logic [ADDR_W-1:0] addr;
  } ex_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } opnd_t;

  // Resolve a pending operand against both result buses.
  // The ALU bus has priority if both carry the same tag.
  function automatic opnd_t snoop(
    input opnd_t             cur,
    input logic              alu_en,
    input logic [TAG_W-1:0]  alu_tag,
    input logic [DATA_W-1:0] alu_data,
    input logic              ls_en,
    input logic [TAG_W-1:0]  ls_tag,
    input logic [DATA_W-1:0] ls_data
  );
    opnd_t r;
    r = cur;
    if (cur.tag != TAG_FREE) begin
      if (alu_en && alu_tag == cur.tag) begin
        r.tag  = TAG_FREE;
        r.data = alu_data;
      end else if (ls_en && ls_tag == cur.tag) begin
        r.tag  = TAG_FREE;
        r.data = ls_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_lowest_one_sel.sv
// Priority select: index of the lowest set bit in vec.
// Ports: vec in, idx out, found out (vec nonzero).
module alu_rs_lowest_one_sel #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both
// operands resolve via CDB snoop, issues oldest-index-first.
// Ports: dispatch (ALU*), CDB (cdbALU*, cdbLS*), rsFull,
// issue bundle (ex*), clk, async active-high rst, clear.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ALUen,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [DATA_W-1:0] ALUoperandO,
  input  logic [DATA_W-1:0] ALUoperandT,
  input  logic [TAG_W-1:0]  ALUtagO,
  input  logic [TAG_W-1:0]  ALUtagT,
  input  logic [TAG_W-1:0]  ALUtagW,
  input  logic [NAME_W-1:0] ALUnameW,
  input  logic [ADDR_W-1:0] ALUaddr,
  input  logic              cdbALUen,
  input  logic [TAG_W-1:0]  cdbALUtag,
  input  logic [DATA_W-1:0] cdbALUdata,
  input  logic              cdbLSen,
  input  logic [TAG_W-1:0]  cdbLStag,
  input  logic [DATA_W-1:0] cdbLSdata,
  output logic              rsFull,
  output logic              exEn,
  output logic [OP_W-1:0]   exOp,
  output logic [DATA_W-1:0] exA,
  output logic [DATA_W-1:0] exB,
  output logic [TAG_W-1:0]  exTagW,
  output logic [NAME_W-1:0] exNameW,
  output logic [ADDR_W-1:0] exAddr
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [OP_W-1:0]    op_q     [ENTRIES];
  logic [OP_W-1:0]    op_d     [ENTRIES];
  logic [DATA_W-1:0]  data_o_q [ENTRIES];
  logic [DATA_W-1:0]  data_o_d [ENTRIES];
  logic [DATA_W-1:0]  data_t_q [ENTRIES];
  logic [DATA_W-1:0]  data_t_d [ENTRIES];
  logic [TAG_W-1:0]   tag_o_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_o_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_t_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_t_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_w_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_w_d  [ENTRIES];
  logic [NAME_W-1:0]  name_w_q [ENTRIES];
  logic [NAME_W-1:0]  name_w_d [ENTRIES];
  logic [ADDR_W-1:0]  addr_q   [ENTRIES];
  logic [ADDR_W-1:0]  addr_d   [ENTRIES];

  logic ex_en_q, ex_en_d;
  ex_t  ex_q, ex_d;

  logic [ENTRIES-1:0] ready;
  logic [IDX_W-1:0]   alloc_idx, iss_idx;
  logic               free_found, iss_found;
  opnd_t              o_new, t_new, o_w, t_w;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = valid_q[i]
               && tag_o_q[i] == TAG_FREE
               && tag_t_q[i] == TAG_FREE;
    end
  end

  assign rsFull = &valid_q;

  alu_rs_lowest_one_sel #(
    .N(ENTRIES),
    .W(IDX_W)
  ) u_free_sel (
    .vec  (~valid_q),
    .idx  (alloc_idx),
    .found(free_found)
  );

  alu_rs_lowest_one_sel #(
    .N(ENTRIES),
    .W(IDX_W)
  ) u_iss_sel (
    .vec  (ready),
    .idx  (iss_idx),
    .found(iss_found)
  );

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    data_o_d = data_o_q;
    data_t_d = data_t_q;
    tag_o_d  = tag_o_q;
    tag_t_d  = tag_t_q;
    tag_w_d  = tag_w_q;
    name_w_d = name_w_q;
    addr_d   = addr_q;
    ex_en_d  = DISABLE;
    ex_d     = ex_q;
    o_w      = '0;
    t_w      = '0;

    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i]) begin
        o_w = snoop('{tag_o_q[i], data_o_q[i]},
                    cdbALUen, cdbALUtag, cdbALUdata,
                    cdbLSen, cdbLStag, cdbLSdata);
        t_w = snoop('{tag_t_q[i], data_t_q[i]},
                    cdbALUen, cdbALUtag, cdbALUdata,
                    cdbLSen, cdbLStag, cdbLSdata);
        tag_o_d[i]  = o_w.tag;
        data_o_d[i] = o_w.data;
        tag_t_d[i]  = t_w.tag;
        data_t_d[i] = t_w.data;
      end
    end

    if (iss_found) begin
      valid_d[iss_idx] = 1'b0;
      ex_en_d          = ENABLE;
      ex_d.op          = op_q[iss_idx];
      ex_d.a           = data_o_q[iss_idx];
      ex_d.b           = data_t_q[iss_idx];
      ex_d.tag_w       = tag_w_q[iss_idx];
      ex_d.name_w      = name_w_q[iss_idx];
      ex_d.addr        = addr_q[iss_idx];
    end

    // Free slot is never the issuing one, so no conflict here.
    if (ALUen && free_found) begin
      valid_d[alloc_idx]  = 1'b1;
      op_d[alloc_idx]     = ALUop;
      tag_o_d[alloc_idx]  = o_new.tag;
      data_o_d[alloc_idx] = o_new.data;
      tag_t_d[alloc_idx]  = t_new.tag;
      data_t_d[alloc_idx] = t_new.data;
      tag_w_d[alloc_idx]  = ALUtagW;
      name_w_d[alloc_idx] = ALUnameW;
      addr_d[alloc_idx]   = ALUaddr;
    end

    if (clear) begin
      valid_d = '0;
      ex_en_d = DISABLE;
      ex_d    = ex_q;
    end
  end

  // Dispatch bypass: operands produced this very cycle.
  assign o_new = snoop('{ALUtagO, ALUoperandO},
                       cdbALUen, cdbALUtag, cdbALUdata,
                       cdbLSen, cdbLStag, cdbLSdata);
  assign t_new = snoop('{ALUtagT, ALUoperandT},
                       cdbALUen, cdbALUtag, cdbALUdata,
                       cdbLSen, cdbLStag, cdbLSdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      ex_en_q     <= DISABLE;
      ex_q.op     <= NOP;
      ex_q.a      <= DATA_FREE;
      ex_q.b      <= DATA_FREE;
      ex_q.tag_w  <= TAG_FREE;
      ex_q.name_w <= NAME_FREE;
      ex_q.addr   <= ADDR_FREE;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]     <= NOP;
        data_o_q[i] <= DATA_FREE;
        data_t_q[i] <= DATA_FREE;
        tag_o_q[i]  <= TAG_FREE;
        tag_t_q[i]  <= TAG_FREE;
        tag_w_q[i]  <= TAG_FREE;
        name_w_q[i] <= NAME_FREE;
        addr_q[i]   <= ADDR_FREE;
      end
    end else begin
      valid_q  <= valid_d;
      ex_en_q  <= ex_en_d;
      ex_q     <= ex_d;
      op_q     <= op_d;
      data_o_q <= data_o_d;
      data_t_q <= data_t_d;
      tag_o_q  <= tag_o_d;
      tag_t_q  <= tag_t_d;
      tag_w_q  <= tag_w_d;
      name_w_q <= name_w_d;
      addr_q   <= addr_d;
    end
  end

  assign exEn    = ex_en_q;
  assign exOp    = ex_q.op;
  assign exA     = ex_q.a;
  assign exB     = ex_q.b;
  assign exTagW  = ex_q.tag_w;
  assign exNameW = ex_q.name_w;
  assign exAddr  = ex_q.addr;

  // Dispatching into a full station loses the op.
  a_no_alloc_full: assert property (
    @(posedge clk) disable iff (rst) !(ALUen && rsFull)
  );

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/CDB vectors,
// expected issues queued in order and checked by a monitor.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              ALUen = 1'b0;
  logic [OP_W-1:0]   ALUop = '0;
  logic [DATA_W-1:0] ALUoperandO = '0;
  logic [DATA_W-1:0] ALUoperandT = '0;
  logic [TAG_W-1:0]  ALUtagO = '0;
  logic [TAG_W-1:0]  ALUtagT = '0;
  logic [TAG_W-1:0]  ALUtagW = '0;
  logic [NAME_W-1:0] ALUnameW = '0;
  logic [ADDR_W-1:0] ALUaddr = '0;
  logic              cdbALUen = 1'b0;
  logic [TAG_W-1:0]  cdbALUtag = '0;
  logic [DATA_W-1:0] cdbALUdata = '0;
  logic              cdbLSen = 1'b0;
  logic [TAG_W-1:0]  cdbLStag = '0;
  logic [DATA_W-1:0] cdbLSdata = '0;
  logic              rsFull;
  logic              exEn;
  logic [OP_W-1:0]   exOp;
  logic [DATA_W-1:0] exA, exB;
  logic [TAG_W-1:0]  exTagW;
  logic [NAME_W-1:0] exNameW;
  logic [ADDR_W-1:0] exAddr;

  int  checks = 0;
  int  errors = 0;
  ex_t exp_q[$];

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst(rst), .clear(clear),
    .ALUen(ALUen), .ALUop(ALUop),
    .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT),
    .ALUtagO(ALUtagO), .ALUtagT(ALUtagT),
    .ALUtagW(ALUtagW), .ALUnameW(ALUnameW),
    .ALUaddr(ALUaddr),
    .cdbALUen(cdbALUen), .cdbALUtag(cdbALUtag),
    .cdbALUdata(cdbALUdata),
    .cdbLSen(cdbLSen), .cdbLStag(cdbLStag),
    .cdbLSdata(cdbLSdata),
    .rsFull(rsFull), .exEn(exEn), .exOp(exOp),
    .exA(exA), .exB(exB), .exTagW(exTagW),
    .exNameW(exNameW), .exAddr(exAddr)
  );

  // Monitor: every exEn cycle is one issue.
  always @(negedge clk) begin
    if (!rst && exEn) begin
      ex_t got;
      ex_t e;
      got = '{exOp, exA, exB, exTagW, exNameW, exAddr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got %h expected none",
                 got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL issue: got %h expected %h", got, e);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op,
                      input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b,
                      input logic [TAG_W-1:0] to,
                      input logic [TAG_W-1:0] tt,
                      input logic [TAG_W-1:0] tw,
                      input logic [NAME_W-1:0] nm,
                      input logic [ADDR_W-1:0] ad);
    ALUen = 1'b1; ALUop = op;
    ALUoperandO = a; ALUoperandT = b;
    ALUtagO = to; ALUtagT = tt;
    ALUtagW = tw; ALUnameW = nm; ALUaddr = ad;
    tick(1);
    ALUen = 1'b0;
  endtask

  task automatic cdb(input logic ae,
                     input logic [TAG_W-1:0] at,
                     input logic [DATA_W-1:0] ad,
                     input logic le,
                     input logic [TAG_W-1:0] lt,
                     input logic [DATA_W-1:0] ld);
    cdbALUen = ae; cdbALUtag = at; cdbALUdata = ad;
    cdbLSen = le; cdbLStag = lt; cdbLSdata = ld;
    tick(1);
    cdbALUen = 1'b0; cdbLSen = 1'b0;
  endtask

  // Fill pattern for the full-station test: tagO per slot.
  logic [TAG_W-1:0] ftag [8] = '{4'h1, 4'h2, 4'hA, 4'h3,
                                 4'hA, 4'h4, 4'h5, 4'h6};

  // Expected issue of fill slot i once its tag's data arrives
  // (data broadcast for tag t is t<<8).
  function automatic ex_t fill_exp(input int i);
    ex_t e;
    e.op     = 6'h10 + 6'(i);
    e.a      = {20'h0, ftag[i], 8'h00};
    e.b      = 32'h40 + 32'(i);
    e.tag_w  = 4'(i + 1);
    e.name_w = 5'h10 + 5'(i);
    e.addr   = 32'h1000 + 32'(i * 4);
    return e;
  endfunction

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);

    chk("rst_exEn", exEn, 0);
    chk("rst_rsFull", rsFull, 0);
    chk("rst_exTagW", exTagW, TAG_FREE);
    chk("rst_exOp", exOp, NOP);
    chk("rst_exA", exA, 0);

    // 1: both operands ready at dispatch
    exp_q.push_back('{6'h01, 32'd5, 32'd7, 4'h3, 5'h04,
                      32'h100});
    disp(6'h01, 32'd5, 32'd7, 4'h0, 4'h0, 4'h3, 5'h04,
         32'h100);
    chk("t1_exEn_n", exEn, 0);
    tick(1);
    chk("t1_exEn_n1", exEn, 1);
    tick(2);

    // 2: operand 1 woken by ALU bus
    exp_q.push_back('{6'h02, 32'h10, 32'h22, 4'h5, 5'h06,
                      32'h104});
    disp(6'h02, 32'hDEAD, 32'h22, 4'h2, 4'h0, 4'h5, 5'h06,
         32'h104);
    tick(1);
    chk("t2_pending", exEn, 0);
    cdb(1'b1, 4'h2, 32'h10, 1'b0, 4'h0, 32'h0);
    chk("t2_no_bypass", exEn, 0);
    tick(1);
    chk("t2_issue", exEn, 1);
    tick(2);

    // 3: dispatch bypass from LS bus
    exp_q.push_back('{6'h03, 32'h33, 32'hAB, 4'h7, 5'h08,
                      32'h108});
    cdbLSen = 1'b1; cdbLStag = 4'h9; cdbLSdata = 32'hAB;
    disp(6'h03, 32'h33, 32'hBEEF, 4'h0, 4'h9, 4'h7, 5'h08,
         32'h108);
    cdbLSen = 1'b0;
    tick(1);
    chk("t3_issue", exEn, 1);
    tick(2);

    // 4: fill, free slot 3, refill slot 3
    for (int i = 0; i < 8; i++) begin
      disp(6'h10 + 6'(i), 32'hF00, 32'h40 + 32'(i),
           ftag[i], 4'h0, 4'(i + 1), 5'h10 + 5'(i),
           32'h1000 + 32'(i * 4));
    end
    chk("t4_full", rsFull, 1);
    exp_q.push_back(fill_exp(3));
    cdb(1'b1, 4'h3, 32'h300, 1'b0, 4'h0, 32'h0);
    chk("t4_full_wake", rsFull, 1);
    tick(1);
    chk("t4_free", rsFull, 0);
    disp(6'h09, 32'hF00, 32'h77, 4'hA, 4'h0, 4'hE, 5'h1E,
         32'h2000);
    chk("t4_refull", rsFull, 1);
    // Slots 2, 3 (new op) and 4 share tag A: index order.
    exp_q.push_back(fill_exp(2));
    exp_q.push_back('{6'h09, 32'hA00, 32'h77, 4'hE, 5'h1E,
                      32'h2000});
    exp_q.push_back(fill_exp(4));
    cdb(1'b1, 4'hA, 32'hA00, 1'b0, 4'h0, 32'h0);
    tick(4);
    exp_q.push_back(fill_exp(0));
    exp_q.push_back(fill_exp(1));
    cdb(1'b1, 4'h1, 32'h100, 1'b1, 4'h2, 32'h200);
    tick(3);
    exp_q.push_back(fill_exp(5));
    exp_q.push_back(fill_exp(6));
    cdb(1'b1, 4'h4, 32'h400, 1'b1, 4'h5, 32'h500);
    tick(3);
    exp_q.push_back(fill_exp(7));
    cdb(1'b1, 4'h6, 32'h600, 1'b0, 4'h0, 32'h0);
    tick(3);
    chk("t4_drained", rsFull, 0);
    chk("t4_sb", exp_q.size(), 0);

    // 5: slots 1 and 5 wake together
    for (int i = 0; i < 6; i++) begin
      disp(6'h20 + 6'(i), 32'h0, 32'h50 + 32'(i),
           (i == 1 || i == 5) ? 4'hC : 4'hD, 4'h0,
           4'(i + 1), 5'(i), 32'h3000 + 32'(i));
    end
    exp_q.push_back('{6'h21, 32'hC00, 32'h51, 4'h2, 5'h01,
                      32'h3001});
    exp_q.push_back('{6'h25, 32'hC00, 32'h55, 4'h6, 5'h05,
                      32'h3005});
    cdb(1'b1, 4'hC, 32'hC00, 1'b0, 4'h0, 32'h0);
    tick(1);
    chk("t5_first", exAddr, 32'h3001);
    tick(1);
    chk("t5_second", exAddr, 32'h3005);
    for (int i = 0; i < 5; i++) begin
      if (i != 1) begin
        exp_q.push_back('{6'h20 + 6'(i), 32'hD00,
                          32'h50 + 32'(i), 4'(i + 1), 5'(i),
                          32'h3000 + 32'(i)});
      end
    end
    cdb(1'b0, 4'h0, 32'h0, 1'b1, 4'hD, 32'hD00);
    tick(6);
    chk("t5_sb", exp_q.size(), 0);

    // 6: clear with 4 entries and a concurrent dispatch
    for (int i = 0; i < 4; i++) begin
      disp(6'h30, 32'h0, 32'h0, 4'h7, 4'h0, 4'h1, 5'h1,
           32'h4000);
    end
    clear = 1'b1;
    disp(6'h31, 32'h1, 32'h2, 4'h0, 4'h0, 4'h2, 5'h2,
         32'h4004);
    clear = 1'b0;
    chk("t6_rsFull", rsFull, 0);
    chk("t6_exEn", exEn, 0);
    cdb(1'b1, 4'h7, 32'h777, 1'b0, 4'h0, 32'h0);
    tick(5);
    chk("t6_no_issue", exEn, 0);
    chk("t6_empty", rsFull, 0);
    chk("final_sb", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
